// File: rtl/bound_flasher_monitor.sv
// Bound-flasher LED bus checker: thermometer decode, segment tracking and violation reporting, 1-cycle latency.
// Optional saturating violation counter under BFM_ERR_COUNTER_EN; without it err_count is tied to 0.
module bound_flasher_monitor #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          led_in,
   input  logic                 flick,
   output logic [4:0]           level,
   output logic                 valid_code,
   output logic [2:0]           seg,
   output logic                 cycle_done,
   output logic                 err,
   output logic [2:0]           err_code,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [1:0] M_IDLE   = 2'd0;
   localparam logic [1:0] M_UP     = 2'd1;
   localparam logic [1:0] M_DOWN   = 2'd2;
   localparam logic [1:0] M_RESYNC = 2'd3;

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_CODE  = 3'd1;
   localparam logic [2:0] E_STEP  = 3'd2;
   localparam logic [2:0] E_BOUND = 3'd3;
   localparam logic [2:0] E_REV   = 3'd4;
   localparam logic [2:0] E_START = 3'd5;
   localparam logic [2:0] E_STALL = 3'd6;

   localparam logic [2:0] SEG_IDLE = 3'd7;

   logic [1:0] state_q, state_d;
   logic [4:0] level_q, level_d;
   logic       valid_q, valid_d;
   logic [2:0] seg_q, seg_d;
   logic       at_bound_q, at_bound_d;
   logic       flick_q;
   logic       err_q, err_d;
   logic [2:0] err_code_q, err_code_d;
   logic       done_q, done_d;

   logic       code_ok;
   logic [4:0] n;
   logic       flick_seen, step_up, step_dn, step_eq;
   logic [4:0] lim;
   logic [2:0] ecode;

   // Segment bound: max for UP segments, min for DOWN segments
   function automatic logic [4:0] seg_limit(input logic [2:0] s);
      case (s)
         3'd0:    seg_limit = 5'd16;
         3'd1:    seg_limit = 5'd6;
         3'd2:    seg_limit = 5'd11;
         3'd4:    seg_limit = 5'd6;
         default: seg_limit = 5'd0;
      endcase
   endfunction

   always_comb begin
      code_ok = 1'b0;
      n       = 5'd0;
      for (int i = 0; i <= 16; i++) begin
         if (led_in == 16'((17'd1 << i) - 17'd1)) begin
            code_ok = 1'b1;
            n       = 5'(i);
         end
      end
   end

   assign flick_seen = flick | flick_q;
   assign step_up    = code_ok && (n == level_q + 5'd1);
   assign step_dn    = code_ok && (level_q != 5'd0) && (n == level_q - 5'd1);
   assign step_eq    = code_ok && (n == level_q);
   assign lim        = seg_limit(seg_q);

   always_comb begin
      state_d    = state_q;
      seg_d      = seg_q;
      at_bound_d = at_bound_q;
      done_d     = 1'b0;
      ecode      = E_NONE;
      level_d    = code_ok ? n : level_q;
      valid_d    = code_ok;
      case (state_q)
         M_IDLE: begin
            if (!code_ok)              ecode = E_CODE;
            else if (step_up) begin
               if (flick_seen) begin
                  state_d    = M_UP;
                  seg_d      = 3'd0;
                  at_bound_d = 1'b0;
               end else        ecode = E_START;
            end else if (!step_eq)     ecode = E_STEP;
         end
         M_UP: begin
            if (!code_ok)                               ecode = E_CODE;
            else if (!(step_up || step_dn || step_eq))  ecode = E_STEP;
            else if (step_up && (n > lim))              ecode = E_BOUND;
            else if (step_dn)                           ecode = E_REV;
            else if (step_eq) begin
               if (at_bound_q) begin
                  state_d    = M_DOWN;
                  seg_d      = seg_q + 3'd1;
                  at_bound_d = 1'b0;
               end else ecode = E_STALL;
            end else at_bound_d = (n == lim);
         end
         M_DOWN: begin
            if (!code_ok)                               ecode = E_CODE;
            else if (!(step_up || step_dn || step_eq))  ecode = E_STEP;
            else if (step_dn && (n < lim))              ecode = E_BOUND;
            else if (step_up) begin
               // Flick reversal is only legal from the flasher's turnaround levels
               if (flick_seen && (level_q == 5'd0 || level_q == 5'd6)) begin
                  state_d    = M_UP;
                  seg_d      = seg_q - 3'd1;
                  at_bound_d = 1'b0;
               end else ecode = E_REV;
            end else if (step_eq) begin
               if (!at_bound_q) ecode = E_STALL;
               else if (seg_q == 3'd5) begin
                  state_d    = M_IDLE;
                  seg_d      = SEG_IDLE;
                  at_bound_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  state_d    = M_UP;
                  seg_d      = seg_q + 3'd1;
                  at_bound_d = 1'b0;
               end
            end else at_bound_d = (n == lim);
         end
         default: begin
            if (code_ok && n == 5'd0) state_d = M_IDLE;
         end
      endcase

      err_d = (ecode != E_NONE);
      if (err_d) begin
         state_d    = M_RESYNC;
         seg_d      = SEG_IDLE;
         at_bound_d = 1'b0;
         done_d     = 1'b0;
      end
      err_code_d = err_d ? ecode : err_code_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= M_IDLE;
         level_q    <= 5'd0;
         valid_q    <= 1'b1;
         seg_q      <= SEG_IDLE;
         at_bound_q <= 1'b0;
         flick_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= E_NONE;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         valid_q    <= valid_d;
         seg_q      <= seg_d;
         at_bound_q <= at_bound_d;
         flick_q    <= flick;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         done_q     <= done_d;
      end
   end

`ifdef BFM_ERR_COUNTER_EN
   logic [ERR_CNT_W-1:0] err_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              err_count_q <= '0;
      else if (err_d && (err_count_q != '1))   err_count_q <= err_count_q + ERR_CNT_W'(1);
   end

   assign err_count = err_count_q;
`else
   assign err_count = '0;
`endif

   assign level      = level_q;
   assign valid_code = valid_q;
   assign seg        = seg_q;
   assign cycle_done = done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Scoreboard bench for bound_flasher_monitor: expectations queued at drive time, compared one cycle later.
module tb_bound_flasher_monitor;
   localparam int W = 8;
`ifdef BFM_ERR_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   led_in;
   logic          flick;
   logic [4:0]    level;
   logic          valid_code;
   logic [2:0]    seg;
   logic          cycle_done;
   logic          err;
   logic [2:0]    err_code;
   logic [W-1:0]  err_count;

   bound_flasher_monitor #(.ERR_CNT_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .led_in     (led_in),
      .flick      (flick),
      .level      (level),
      .valid_code (valid_code),
      .seg        (seg),
      .cycle_done (cycle_done),
      .err        (err),
      .err_code   (err_code),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lvl;
      bit vld;
      int sg;
      bit er;
      int code;
      bit done;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_level = 0;
   int   exp_code  = 0;
   int   exp_cnt   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] thermo(input int k);
      logic [16:0] t;
      t = (17'd1 << k) - 17'd1;
      return t[15:0];
   endfunction

   // Push the expectation for a sample driven now; the DUT answers after the next rising edge
   task automatic drive(input logic [15:0] led, input bit f, input int sg, input int ec, input bit dn);
      exp_t        e;
      logic [16:0] x;
      led_in = led;
      flick  = f;
      x      = {1'b0, led};
      e.vld  = ((x & (x + 17'd1)) == 17'd0);
      if (e.vld) exp_level = $countones(led);
      if (ec != 0) begin
         exp_code = ec;
         if (CNT_EN && exp_cnt < (1 << W) - 1) exp_cnt++;
      end
      e.lvl  = exp_level;
      e.sg   = sg;
      e.er   = (ec != 0);
      e.code = exp_code;
      e.done = dn;
      e.cnt  = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic send_raw(input logic [15:0] led, input bit f, input int sg, input int ec, input bit dn);
      @(negedge clk);
      drive(led, f, sg, ec, dn);
   endtask

   task automatic lv(input int k, input bit f, input int sg, input int ec = 0, input bit dn = 0);
      send_raw(thermo(k), f, sg, ec, dn);
   endtask

   task automatic ramp(input int a, input int b, input int sg);
      if (b > a) for (int i = a + 1; i <= b; i++) lv(i, 0, sg);
      else       for (int i = a - 1; i >= b; i--) lv(i, 0, sg);
   endtask

   task automatic leg(input int a, input int b, input int sg, input int nxt, input bit dn);
      ramp(a, b, sg);
      lv(b, 0, nxt, 0, dn);
   endtask

   task automatic full_cycle();
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      leg(16, 6, 1, 2, 0);
      leg(6, 11, 2, 3, 0);
      leg(11, 0, 3, 4, 0);
      leg(0, 6, 4, 5, 0);
      leg(6, 0, 5, 7, 1);
   endtask

   task automatic reset_vals(input string pfx);
      check({pfx, "_level"}, level, 0);
      check({pfx, "_valid"}, valid_code, 1);
      check({pfx, "_seg"}, seg, 7);
      check({pfx, "_err"}, err, 0);
      check({pfx, "_code"}, err_code, 0);
      check({pfx, "_done"}, cycle_done, 0);
      check({pfx, "_count"}, err_count, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("level", level, e.lvl);
            check("valid_code", valid_code, e.vld);
            check("seg", seg, e.sg);
            check("err", err, e.er);
            check("err_code", err_code, e.code);
            check("cycle_done", cycle_done, e.done);
            check("err_count", err_count, e.cnt);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin : stim
      reset  = 1'b0;
      led_in = 16'h0000;
      flick  = 1'b0;
      repeat (2) @(negedge clk);
      reset_vals("por");
      reset = 1'b1;

      // Clean sequence, then flick reversals in seg1 (at 6) and seg5 (at 0)
      full_cycle();
      lv(0, 0, 7);
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      ramp(16, 6, 1);
      lv(7, 1, 0);
      leg(7, 16, 0, 1, 0);
      leg(16, 6, 1, 2, 0);
      leg(6, 11, 2, 3, 0);
      leg(11, 0, 3, 4, 0);
      leg(0, 6, 4, 5, 0);
      ramp(6, 0, 5);
      lv(1, 1, 4);
      leg(1, 6, 4, 5, 0);
      leg(6, 0, 5, 7, 1);

      // Illegal code, then RESYNC ignores junk until a clean zero
      lv(0, 1, 7);
      ramp(0, 5, 0);
      send_raw(16'h00F5, 0, 7, 1, 0);
      send_raw(16'h0F0F, 0, 7, 0, 0);
      lv(3, 0, 7);
      lv(0, 0, 7);

      // Skip in seg0, spontaneous start, jump from IDLE
      lv(0, 1, 7);
      ramp(0, 3, 0);
      lv(5, 0, 7, 2);
      lv(0, 0, 7);
      lv(1, 0, 7, 5);
      lv(0, 0, 7);
      lv(2, 0, 7, 2);
      lv(0, 0, 7);

      // Stall at the bound (third repeat) and before the bound
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      lv(16, 0, 7, 6);
      lv(0, 0, 7);
      lv(0, 1, 7);
      ramp(0, 4, 0);
      lv(4, 0, 7, 6);
      lv(0, 0, 7);

      // Bound violations: above seg2 max, below seg1 min
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      leg(16, 6, 1, 2, 0);
      ramp(6, 11, 2);
      lv(12, 0, 7, 3);
      lv(0, 0, 7);
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      ramp(16, 6, 1);
      lv(5, 0, 7, 3);
      lv(0, 0, 7);

      // Early reversal in UP, and flick reversal away from a turnaround level
      lv(0, 1, 7);
      ramp(0, 5, 0);
      lv(4, 0, 7, 4);
      lv(0, 0, 7);
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      ramp(16, 10, 1);
      lv(11, 1, 7, 4);
      lv(0, 0, 7);

      // Reset in seg2 at level 9; flick history must clear
      lv(0, 1, 7);
      leg(0, 16, 0, 1, 0);
      leg(16, 6, 1, 2, 0);
      ramp(6, 9, 2);
      @(negedge clk);
      reset = 1'b0;
      flick = 1'b1;
      #1;
      reset_vals("rst_async");
      @(posedge clk);
      #1;
      reset_vals("rst_held");
      @(negedge clk);
      reset     = 1'b1;
      exp_level = 0;
      exp_code  = 0;
      exp_cnt   = 0;
      drive(thermo(1), 0, 7, 5, 0);
      lv(0, 0, 7);
      full_cycle();

      // Saturation of the violation counter
      for (int i = 0; i < 260; i++) begin
         lv(1, 0, 7, 5);
         lv(0, 0, 7);
      end

      @(negedge clk);
      @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bound_flasher_monitor.md
# bound_flasher_monitor

Sequence checker on the receive side of the bound-flasher LED bus. It decodes the 16-bit thermometer LED pattern into a lamp count and tracks the flasher's up/down segment sequence. Each cycle it checks that sequence, including the flick-driven reversals. It sits beside the flasher in the top level and feeds error status to the debug/status register block.

## Interface
- ERR_CNT_W, 8, width of saturating error counter
- clk  in  1  sampling clock, same clock as the flasher
- reset  in  1  asynchronous, active-low
- led_in  in  16  observed LED bus
- flick  in  1  observed flick input, synchronous to clk
- level  out  5  decoded lamp count 0..16 of the last sample
- valid_code  out  1  last sample was a legal thermometer code
- seg  out  3  current segment 0..5 (7 = IDLE/RESYNC)
- cycle_done  out  1  one-cycle pulse when a full sequence completes
- err  out  1  one-cycle pulse on any violation
- err_code  out  3  cause of the last violation, held until the next one
- err_count  out  ERR_CNT_W  saturating violation count

## Operation
- Decode: valid_code=1 iff led_in == (1<<n)-1 for some n in 0..16, and then level=n. On an invalid code, level holds its previous value.
- Segment table:
  - seg0 UP, max 16
  - seg1 DOWN, min 6
  - seg2 UP, max 11
  - seg3 DOWN, min 0
  - seg4 UP, max 6
  - seg5 DOWN, min 0
- States:
  - M_IDLE: expects level 0. Level 1 with flick_seen → M_UP, seg0.
  - M_UP: each sample must be prev+1 and ≤ max. A sample equal to max sets at_bound. The next sample must repeat max (hold); that sample moves the monitor to M_DOWN, seg+1.
  - M_DOWN: each sample must be prev-1 and ≥ min. Reaching min sets at_bound, and the next sample must repeat min.
    - If seg<5, the hold sample moves the monitor to M_UP, seg+1.
    - If seg=5, the hold sample pulses cycle_done and moves the monitor to M_IDLE.
  - M_DOWN flick reversal: a sample of prev+1, where prev ∈ {0,6} and flick_seen=1, is legal. It moves the monitor to M_UP with seg-1 and clears at_bound.
  - M_RESYNC: entered on any error. Exit to M_IDLE on the first valid sample with level 0. No checks run while in RESYNC.
- flick_seen = flick sampled high at the current or previous edge. This covers the flasher's asynchronous flick path.
- Error codes (priority 1 highest):
  - 1 E_CODE: invalid thermometer code
  - 2 E_STEP: |level-prev| > 1
  - 3 E_BOUND: UP above max, or DOWN below min
  - 4 E_REV: direction change before the bound without a legal flick
  - 5 E_START: leaving 0 in IDLE without flick_seen
  - 6 E_STALL: level repeated when not at_bound, or repeated twice at the bound
- Any error: err=1, err_code updated, err_count+1 (saturates at all-ones), state → M_RESYNC.
- Simultaneous events: a single error pulse per cycle, reporting the highest-priority code. cycle_done is suppressed in any cycle that errors.

## Timing
- All outputs are registered. Sample k at edge k drives level/valid_code/seg/err/err_code/cycle_done after edge k: one-cycle latency from led_in.
- Reset values:
  - level=0, valid_code=1, seg=7
  - err=0, err_code=0, cycle_done=0, err_count=0
  - state M_IDLE, prev=0, at_bound=0, flick history=0
- Reset mid-sequence: immediate return to the reset values, with no error reported. The first sample after reset release is checked against M_IDLE.
- err and cycle_done are single-cycle pulses and are never held.

## Configuration
- BFM_ERR_COUNTER_EN defined: err_count is implemented as specified.
- BFM_ERR_COUNTER_EN not defined: the counter is removed and err_count is tied to 0. err and err_code are unaffected.

## Test plan
- Clean run: flick at IDLE, then 0→16, hold, 16→6, hold, 6→11, hold, 11→0, hold, 0→6, hold, 6→0, hold → one cycle_done pulse, err never asserted, seg ends at 7.
- Flick reversal: during seg1, at level 6 with flick high, level goes 7 → no err, seg=0. The sequence then climbs back to 16 and continues legally.
- Illegal code: led_in=16'h00F5 mid-seg0 → err=1, err_code=1, err_count=1, RESYNC. led_in=0 → IDLE.
- Skip and spontaneous start: 3→5 in seg0 → err_code=2. Level 0→1 in IDLE with flick low → err_code=5.
- Stall and saturation: level held 3 cycles at 16 → err_code=6. Repeated errors drive err_count to 255 and it stays there. With BFM_ERR_COUNTER_EN undefined, err_count stays 0.
- Reset mid-seg2: assert reset at level 9 → all outputs at reset values. Sequence from IDLE after release → no error.
